// File: rtl/uart_serial_engine.sv
// uart_serial_engine
//
// Serial engine that sits behind the UART control register. It sends one
// 8N1 byte each time the register's SEND bit is seen set, receives 8N1
// bytes from the RX pin, and reports completion through the register's
// hardware-write port.
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       asynchronous active-high reset
//   ctrl_i      current control register value (bit0 SEND, bit1 NEW)
//   cpu_wr_i    CPU write strobe; it wins over any hardware write
//   tx_data_i   byte to send, captured when a frame starts
//   rx_i        asynchronous serial input, idle high
//   tx_o        serial output, idle high
//   tx_busy_o   high while a TX frame is in progress (START..DONE)
//   rx_data_o   last correctly framed received byte
//   wr2_send_o  pulse: TX frame finished, SEND cleared in data2_o
//   wr2_new_o   pulse: RX byte stored, NEW set in data2_o
//   data2_o     control word written with either pulse
//
// TX states
//   state    | meaning
//   TX_IDLE  | line idle, waiting for SEND
//   TX_START | driving the start bit
//   TX_DATA  | driving data bits, LSB first
//   TX_STOP  | driving the stop bit
//   TX_DONE  | wr2_send_o high; held while the CPU write collides
//
// RX states
//   state    | meaning
//   RX_IDLE  | waiting for a low level on the synchronized input
//   RX_START | half-bit wait, then confirm the start bit
//   RX_DATA  | sampling data bits, LSB first
//   RX_STOP  | sampling the stop bit

module uart_serial_engine #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ctrl_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  tx_data_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        tx_busy_o,
  output logic [7:0]  rx_data_o,
  output logic        wr2_send_o,
  output logic        wr2_new_o,
  output logic [31:0] data2_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  tx_state_t     tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_idx, tx_idx_nx;
  logic [7:0]    tx_byte, tx_byte_nx;
  logic          tx_q, tx_nx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_byte  <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_nx;
      tx_cnt   <= tx_cnt_nx;
      tx_idx   <= tx_idx_nx;
      tx_byte  <= tx_byte_nx;
      tx_q     <= tx_nx;
    end
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_idx_nx   = tx_idx;
    tx_byte_nx  = tx_byte;
    tx_nx       = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (ctrl_i[0]) begin
          tx_state_nx = TX_START;
          tx_byte_nx  = tx_data_i;
          tx_idx_nx   = '0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) tx_state_nx = TX_DATA;
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          if (tx_idx == 3'd7) tx_state_nx = TX_STOP;
          else                tx_idx_nx   = tx_idx + 3'd1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) tx_state_nx = TX_DONE;
      end
      TX_DONE: begin
        // A colliding CPU write drops our hardware update; retry next cycle.
        if (!cpu_wr_i) tx_state_nx = TX_IDLE;
      end
      default: tx_state_nx = TX_IDLE;
    endcase

    if (tx_state_nx != tx_state || tx_cnt == BIT_LAST ||
        tx_state == TX_IDLE || tx_state == TX_DONE)
      tx_cnt_nx = '0;
    else
      tx_cnt_nx = tx_cnt + 1'b1;

    // Line level is registered from the next state so tx_o is glitch-free.
    case (tx_state_nx)
      TX_START: tx_nx = 1'b0;
      TX_DATA:  tx_nx = tx_byte_nx[tx_idx_nx];
      default:  tx_nx = 1'b1;
    endcase
  end

  assign tx_o       = tx_q;
  assign tx_busy_o  = (tx_state != TX_IDLE);
  assign wr2_send_o = (tx_state == TX_DONE);

  // ---------------------------------------------------------------- RX
  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  rx_state_t     rx_state, rx_state_nx;
  logic [CW-1:0] rx_cnt, rx_cnt_nx;
  logic [2:0]    rx_idx, rx_idx_nx;
  logic [7:0]    rx_shift, rx_shift_nx;
  logic [7:0]    rx_data_q, rx_data_nx;
  logic          new_pend, new_pend_nx;
  logic          rx_s1, rx_s2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_cnt    <= '0;
      rx_idx    <= '0;
      rx_shift  <= '0;
      rx_data_q <= '0;
      new_pend  <= 1'b0;
    end else begin
      rx_s1     <= rx_i;
      rx_s2     <= rx_s1;
      rx_state  <= rx_state_nx;
      rx_cnt    <= rx_cnt_nx;
      rx_idx    <= rx_idx_nx;
      rx_shift  <= rx_shift_nx;
      rx_data_q <= rx_data_nx;
      new_pend  <= new_pend_nx;
    end
  end

  always_comb begin
    rx_state_nx = rx_state;
    rx_idx_nx   = rx_idx;
    rx_shift_nx = rx_shift;
    rx_data_nx  = rx_data_q;
    // A pending NEW pulse survives only a cycle in which the CPU write won.
    new_pend_nx = new_pend & cpu_wr_i;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_s2) begin
          rx_state_nx = RX_START;
          rx_idx_nx   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          if (rx_s2) rx_state_nx = RX_IDLE;
          else       rx_state_nx = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_shift_nx = {rx_s2, rx_shift[7:1]};
          if (rx_idx == 3'd7) rx_state_nx = RX_STOP;
          else                rx_idx_nx   = rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_state_nx = RX_IDLE;
          // Framing errors are dropped silently; a good byte overwrites
          // whatever is stored and merges with any still-pending pulse.
          if (rx_s2) begin
            rx_data_nx  = rx_shift;
            new_pend_nx = 1'b1;
          end
        end
      end
      default: rx_state_nx = RX_IDLE;
    endcase

    if (rx_state_nx != rx_state || rx_cnt == BIT_LAST || rx_state == RX_IDLE)
      rx_cnt_nx = '0;
    else
      rx_cnt_nx = rx_cnt + 1'b1;
  end

  assign rx_data_o = rx_data_q;
  assign wr2_new_o = new_pend;

  // ------------------------------------------------------- write-back word
  assign data2_o = {ctrl_i[31:2],
                    wr2_new_o  ? 1'b1 : ctrl_i[1],
                    wr2_send_o ? 1'b0 : ctrl_i[0]};

endmodule
